// File: rtl/butterfly_sequencer_if.sv
// Handshake and RAM-address bundle between the top-level control and the butterfly sequencer.
// The master side is the controller; the slave side is the sequencer.
interface butterfly_sequencer_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] length;
    logic                  hold;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH-1:0] address_a;
    logic [ADDR_WIDTH-1:0] address_b;
    logic [3:0]            wren;
    logic [ADDR_WIDTH-1:0] count;

    modport master (
        output start, base, length, hold,
        input  busy, done, error, address_a, address_b, wren, count
    );

    modport slave (
        input  start, base, length, hold,
        output busy, done, error, address_a, address_b, wren, count
    );
endinterface

// File: rtl/butterfly_sequencer.sv
// Walks a range of butterfly pairs over two dual-port RAM banks: read, wait out the RAM
// latency, then write sum/difference back in place through all four write ports.
module butterfly_sequencer #(
    parameter int ADDR_WIDTH  = 9,
    parameter int HALF_OFFSET = 256,
    parameter int RD_LATENCY  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    butterfly_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        FINISH
    } state_t;

    localparam int              LW        = ADDR_WIDTH + 1;
    localparam logic [LW-1:0]   HALF_W    = LW'(HALF_OFFSET);
    localparam logic [1:0]      WAIT_LOAD = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [ADDR_WIDTH-1:0] count_reg, count_next;
    logic [ADDR_WIDTH-1:0] len_reg, len_next;
    logic [1:0]            wait_reg, wait_next;
    logic [3:0]            wren_reg, wren_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  error_reg, error_next;

    logic [LW-1:0]         base_w;
    logic [LW-1:0]         length_w;
    logic [LW-1:0]         room;
    logic [ADDR_WIDTH-1:0] eff_len;
    logic [ADDR_WIDTH-1:0] count_inc;

    // Clamp the requested run so port A never leaves the lower half.
    always_comb begin
        base_w   = LW'(bus.base);
        length_w = LW'(bus.length);
        room     = '0;
        eff_len  = '0;
        if (base_w < HALF_W) begin
            room    = HALF_W - base_w;
            eff_len = (length_w < room) ? bus.length : room[ADDR_WIDTH-1:0];
        end
    end

    assign count_inc = count_reg + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            count_reg <= '0;
            len_reg   <= '0;
            wait_reg  <= '0;
            wren_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            count_reg <= count_next;
            len_reg   <= len_next;
            wait_reg  <= wait_next;
            wren_reg  <= wren_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            error_reg <= error_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        count_next = count_reg;
        len_next   = len_reg;
        wait_next  = wait_reg;
        wren_next  = 4'b0000;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        error_next = error_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    error_next = (LW'(eff_len) != length_w);
                    count_next = '0;
                    len_next   = eff_len;
                    if (eff_len == '0) begin
                        state_next = FINISH;
                        done_next  = 1'b1;
                    end else begin
                        addr_next  = bus.base;
                        busy_next  = 1'b1;
                        state_next = READ;
                    end
                end
            end
            READ: begin
                if (!bus.hold) begin
                    if (RD_LATENCY == 1) begin
                        wren_next  = 4'b1111;
                        state_next = WRITE;
                    end else begin
                        wait_next  = WAIT_LOAD;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_reg == 2'd0) begin
                    wren_next  = 4'b1111;
                    state_next = WRITE;
                end else begin
                    wait_next = wait_reg - 2'd1;
                end
            end
            WRITE: begin
                count_next = count_inc;
                if (count_inc == len_reg) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = FINISH;
                end else begin
                    addr_next  = addr_reg + 1'b1;
                    state_next = READ;
                end
            end
            FINISH: begin
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.address_a = addr_reg;
    assign bus.address_b = addr_reg + ADDR_WIDTH'(HALF_OFFSET);
    assign bus.wren      = wren_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.error     = error_reg;
    assign bus.count     = count_reg;
endmodule

// File: tb/tb_butterfly_sequencer.sv
// Directed bench for butterfly_sequencer: one instance at read latency 1, one at latency 3.
module tb_butterfly_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    butterfly_sequencer_if #(.ADDR_WIDTH(9)) bus1 ();
    butterfly_sequencer_if #(.ADDR_WIDTH(9)) bus3 ();

    butterfly_sequencer #(.ADDR_WIDTH(9), .HALF_OFFSET(256), .RD_LATENCY(1)) u_lat1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    butterfly_sequencer #(.ADDR_WIDTH(9), .HALF_OFFSET(256), .RD_LATENCY(3)) u_lat3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic [8:0] b,
                         input logic [8:0] l, input logic h);
        if (sel == 3) begin
            bus3.start = st; bus3.base = b; bus3.length = l; bus3.hold = h;
        end else begin
            bus1.start = st; bus1.base = b; bus1.length = l; bus1.hold = h;
        end
    endtask

    // One run from start to two cycles past DONE. Cycle n is the period after the n-th
    // rising edge counting the start-sampling edge as edge 1, matching DONE at len*(L+1)+1.
    task automatic run(input string tag, input int sel, input logic [8:0] b, input logic [8:0] l,
                       input int hold_cyc, input int restart_cyc,
                       input int exp_pulses, input int exp_p0, input int exp_p1,
                       input int exp_done, input int exp_err);
        int pulses = 0, p0 = -1, p1 = -1, done_cyc = 0, done_cnt = 0, bad = 0, cyc = 0;
        logic [8:0] exp_a = b;
        logic [3:0] w;
        logic [8:0] a, ab;
        logic       d, bz;
        @(negedge clk);
        drive(sel, 1'b1, b, l, hold_cyc > 0);
        while (cyc < 2000 && !(done_cyc != 0 && cyc >= done_cyc + 2)) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (cyc == 1) drive(sel, 1'b0, b, l, hold_cyc > 0);
            if (cyc == hold_cyc + 1) drive(sel, 1'b0, b, l, 1'b0);
            if (cyc == restart_cyc) drive(sel, 1'b1, 9'd100, 9'd50, 1'b0);
            if (cyc == restart_cyc + 1) drive(sel, 1'b0, b, l, 1'b0);
            w  = (sel == 3) ? bus3.wren : bus1.wren;
            a  = (sel == 3) ? bus3.address_a : bus1.address_a;
            ab = (sel == 3) ? bus3.address_b : bus1.address_b;
            d  = (sel == 3) ? bus3.done : bus1.done;
            bz = (sel == 3) ? bus3.busy : bus1.busy;
            if (w != 4'h0) begin
                if (w != 4'hF || a != exp_a || ab != a + 9'd256 || !bz) bad++;
                if (pulses == 0) p0 = cyc;
                if (pulses == 1) p1 = cyc;
                pulses++;
                exp_a = exp_a + 9'd1;
            end
            if (d) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
        end
        check({tag, "_done_cycle"}, done_cyc, exp_done);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_wren_pulses"}, pulses, exp_pulses);
        check({tag, "_first_write_cycle"}, p0, exp_p0);
        check({tag, "_second_write_cycle"}, p1, exp_p1);
        check({tag, "_bad_writes"}, bad, 0);
        check({tag, "_count"}, int'((sel == 3) ? bus3.count : bus1.count), exp_pulses);
        check({tag, "_error"}, int'((sel == 3) ? bus3.error : bus1.error), exp_err);
        check({tag, "_busy_idle"}, int'((sel == 3) ? bus3.busy : bus1.busy), 0);
    endtask

    initial begin
        int waited;
        int done_seen;
        drive(1, 1'b0, 9'd0, 9'd0, 1'b0);
        drive(3, 1'b0, 9'd0, 9'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_addr_a", int'(bus1.address_a), 0);
        check("reset_addr_b", int'(bus1.address_b), 256);
        check("reset_wren", int'(bus1.wren), 0);
        check("reset_busy", int'(bus1.busy), 0);
        check("reset_done", int'(bus1.done), 0);
        check("reset_error", int'(bus1.error), 0);
        check("reset_count", int'(bus1.count), 0);
        rst = 1'b0;

        run("full", 1, 9'd0, 9'd256, 0, -10, 256, 2, 4, 513, 0);
        run("clamp", 1, 9'd250, 9'd10, 0, -10, 6, 2, 4, 13, 1);
        run("oob", 1, 9'd300, 9'd4, 0, -10, 0, -1, -1, 1, 1);
        run("zero", 1, 9'd0, 9'd0, 0, -10, 0, -1, -1, 1, 0);
        run("lat3_hold", 3, 9'd10, 9'd2, 3, -10, 2, 7, 11, 12, 0);
        run("restart", 1, 9'd5, 9'd8, 0, 5, 8, 2, 4, 17, 0);

        // Reset landing in a WRITE cycle of a 20-pair run.
        @(negedge clk);
        drive(1, 1'b1, 9'd0, 9'd20, 1'b0);
        @(negedge clk);
        drive(1, 1'b0, 9'd0, 9'd20, 1'b0);
        waited = 0;
        while (bus1.wren != 4'hF && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("mid_reset_found_write", int'(bus1.wren), 15);
        rst = 1'b1;
        #1;
        check("mid_reset_wren", int'(bus1.wren), 0);
        check("mid_reset_busy", int'(bus1.busy), 0);
        check("mid_reset_addr", int'(bus1.address_a), 0);
        check("mid_reset_count", int'(bus1.count), 0);
        check("mid_reset_error", int'(bus1.error), 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus1.done) done_seen++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus1.done || bus1.wren != 4'h0) done_seen++;
        end
        check("mid_reset_no_done", done_seen, 0);

        run("after_reset", 1, 9'd0, 9'd256, 0, -10, 256, 2, 4, 513, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/butterfly_sequencer.md
Name: butterfly_sequencer

Overview:
- Sequencer for the two-bank butterfly datapath: RAM0 and RAM1, each dual-port.
- Port A of both banks addresses the lower half. Port B addresses the upper half (A + HALF_OFFSET).
- Per pair, the block issues a read, waits the RAM read latency, then asserts all four write enables so the sum and difference results are written back in place.
- Driven by a start/done handshake from the top-level control, with programmable base, length and a stall input.

Parameters:
ADDR_WIDTH, 9, RAM address width
HALF_OFFSET, 256, distance between port A and port B addresses; also the upper bound for valid A addresses
RD_LATENCY, 1, RAM read latency in cycles; legal range 1..3

Ports:
CLOCK_I  input  1  system clock, rising edge
RESET_I  input  1  reset, asynchronous, active-high
START_I  input  1  start request, sampled in IDLE only
BASE_I  input  ADDR_WIDTH  first port-A address, latched on accepted start
LENGTH_I  input  ADDR_WIDTH  number of pairs to process, latched on accepted start
HOLD_I  input  1  stall, sampled in READ only
BUSY_O  output  1  high from the cycle after an accepted start through the last WRITE
DONE_O  output  1  one-cycle completion pulse
ERROR_O  output  1  high when the latched range was clamped; sticky until the next accepted start
ADDRESS_A_O  output  ADDR_WIDTH  port-A address to both RAMs
ADDRESS_B_O  output  ADDR_WIDTH  port-B address to both RAMs
WREN_O  output  4  write enables: {RAM1 port B, RAM1 port A, RAM0 port B, RAM0 port A}
COUNT_O  output  ADDR_WIDTH  pairs completed in the current or last run

Behaviour:
- Reset (asynchronous, immediate):
  - State IDLE.
  - ADDRESS_A_O = 0, WREN_O = 0, BUSY_O = 0, DONE_O = 0, ERROR_O = 0, COUNT_O = 0.
  - Reset mid-run abandons the run. No further writes occur and no DONE_O pulse is produced.
- ADDRESS_B_O = ADDRESS_A_O + HALF_OFFSET, combinational, wraps modulo 2^ADDR_WIDTH.
- All other outputs are registered.
- States: IDLE, READ, WAIT, WRITE, FINISH.
- IDLE:
  - START_I = 1 computes the effective length: len = min(LENGTH_I, HALF_OFFSET - BASE_I); BASE_I >= HALF_OFFSET gives len = 0.
  - ERROR_O <= (len != LENGTH_I). COUNT_O <= 0.
  - len = 0: go to FINISH with no writes.
  - Otherwise: ADDRESS_A_O <= BASE_I, BUSY_O <= 1, go to READ.
- READ:
  - Address is presented; WREN_O = 0.
  - HOLD_I = 1: stay in READ, address unchanged.
  - HOLD_I = 0 and RD_LATENCY = 1: WREN_O <= 4'b1111, go to WRITE.
  - HOLD_I = 0 and RD_LATENCY > 1: load wait counter with RD_LATENCY-2, go to WAIT.
- WAIT:
  - Decrement the wait counter; address held.
  - At 0: WREN_O <= 4'b1111, go to WRITE.
  - HOLD_I is ignored.
- WRITE:
  - WREN_O = 4'b1111 for exactly this one cycle; address unchanged from READ.
  - WREN_O <= 0, COUNT_O <= COUNT_O + 1.
  - If COUNT_O + 1 == len: go to FINISH, BUSY_O <= 0.
  - Otherwise: ADDRESS_A_O <= ADDRESS_A_O + 1, go to READ.
  - A scheduled write always completes; HOLD_I has no effect.
- FINISH: DONE_O = 1 for one cycle, BUSY_O = 0, go to IDLE.
- START_I outside IDLE is ignored; it is not queued.
- Timing without stalls:
  - Each pair takes RD_LATENCY + 1 cycles.
  - With the START-sampling edge as cycle 0, DONE_O is high in cycle len*(RD_LATENCY+1) + 1.
  - Each HOLD_I cycle in READ adds one cycle.
- WREN_O is never asserted in IDLE, READ, WAIT or FINISH.
- WREN_O is never asserted for an address outside [BASE_I, BASE_I+len-1].

Test Plan:
1. Reset, then START_I with BASE_I=0, LENGTH_I=256, RD_LATENCY=1 -> 256 single-cycle WREN_O=4'hF pulses at A=0..255 / B=256..511; DONE_O in cycle 513; COUNT_O=256; ERROR_O=0.
2. BASE_I=250, LENGTH_I=10 -> clamped to 6 pairs, A=250..255; ERROR_O=1; DONE_O in cycle 13.
3. BASE_I=300, LENGTH_I=4 -> no WREN_O; DONE_O in cycle 1; ERROR_O=1. LENGTH_I=0 with BASE_I=0 -> DONE_O in cycle 1, ERROR_O=0.
4. RD_LATENCY=3, BASE_I=10, LENGTH_I=2, HOLD_I high for 3 cycles during the first READ -> WREN_O at cycles 7 and 11 with A=10 and A=11; DONE_O in cycle 12.
5. START_I pulsed while BUSY_O=1 -> ignored; address sequence and COUNT_O unaffected.
6. RESET_I asserted in a WRITE cycle of a 20-pair run -> WREN_O drops asynchronously; all outputs at reset values; no DONE_O; a new run afterwards behaves as in scenario 1.
